icache_fetch: RTL and testbench

//  Direct-mapped instruction cache between the instruction fetcher and MemCtrl's IF port.

---
 rtl/icache_fetch.sv | 136 +++++++++++++
 tb/tb_icache_fetch.sv | 284 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/icache_fetch.sv
// Direct-mapped, read-only instruction cache sitting between the fetcher and the MemCtrl IF port.
// A miss fetches one full line, installs it, then the lookup is retried from IDLE.
module icache_fetch #(
    parameter int unsigned LINE_BYTES = 64,
    parameter int unsigned NUM_LINES  = 16
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    rdy,
    input  logic                    rollback,
    input  logic                    fetch_en,
    input  logic [31:0]             fetch_pc,
    output logic                    inst_valid,
    output logic [31:0]             inst,
    output logic [31:0]             inst_pc,
    output logic                    mem_if_en,
    output logic [31:0]             mem_if_pc,
    input  logic                    mem_if_done,
    input  logic [LINE_BYTES*8-1:0] mem_if_data
);

    localparam int unsigned OffW  = $clog2(LINE_BYTES);
    localparam int unsigned IdxW  = $clog2(NUM_LINES);
    localparam int unsigned TagW  = 32 - OffW - IdxW;
    localparam int unsigned LineW = LINE_BYTES * 8;

    typedef enum logic [0:0] {StIdle, StWait} state_e;

    state_e state_q, state_d;

    logic [NUM_LINES-1:0] valid_q;
    logic [TagW-1:0]      tag_q  [NUM_LINES];
    logic [LineW-1:0]     data_q [NUM_LINES];

    logic        inst_valid_q, inst_valid_d;
    logic [31:0] inst_q, inst_d;
    logic [31:0] inst_pc_q, inst_pc_d;
    logic        mem_if_en_q, mem_if_en_d;
    logic [31:0] mem_if_pc_q, mem_if_pc_d;
    logic        fill_we;

    logic [IdxW-1:0]  lk_idx;
    logic [TagW-1:0]  lk_tag;
    logic [IdxW-1:0]  fill_idx;
    logic [TagW-1:0]  fill_tag;
    logic [31:0]      word_sel;
    logic [31:0]      line_base;
    logic [LineW-1:0] rd_line;
    logic             hit;

    assign lk_idx    = fetch_pc[OffW +: IdxW];
    assign lk_tag    = fetch_pc[31 -: TagW];
    assign fill_idx  = mem_if_pc_q[OffW +: IdxW];
    assign fill_tag  = mem_if_pc_q[31 -: TagW];
    assign word_sel  = (fetch_pc & (LINE_BYTES - 1)) >> 2;
    assign line_base = fetch_pc & ~(LINE_BYTES - 1);
    assign hit       = valid_q[lk_idx] && (tag_q[lk_idx] == lk_tag);

    // Shift the selected word down to bit 0 rather than using a variable part-select.
    always_comb begin
        rd_line = data_q[lk_idx] >> (word_sel * 32'd32);
    end

    always_comb begin
        state_d      = state_q;
        inst_valid_d = 1'b0;
        inst_d       = inst_q;
        inst_pc_d    = inst_pc_q;
        mem_if_en_d  = mem_if_en_q;
        mem_if_pc_d  = mem_if_pc_q;
        fill_we      = 1'b0;
        if (rdy) begin
            unique case (state_q)
                StIdle: begin
                    if (fetch_en && !rollback) begin
                        if (hit) begin
                            inst_valid_d = 1'b1;
                            inst_d       = rd_line[31:0];
                            inst_pc_d    = fetch_pc;
                        end else begin
                            mem_if_en_d = 1'b1;
                            mem_if_pc_d = line_base;
                            state_d     = StWait;
                        end
                    end
                end
                StWait: begin
                    // MemCtrl cannot abort an IF, so rollback does not cancel the fill.
                    if (mem_if_done) begin
                        fill_we     = 1'b1;
                        mem_if_en_d = 1'b0;
                        state_d     = StIdle;
                    end
                end
                default: state_d = StIdle;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= StIdle;
            valid_q      <= '0;
            inst_valid_q <= 1'b0;
            inst_q       <= '0;
            inst_pc_q    <= '0;
            mem_if_en_q  <= 1'b0;
            mem_if_pc_q  <= '0;
        end else begin
            state_q      <= state_d;
            inst_valid_q <= inst_valid_d;
            inst_q       <= inst_d;
            inst_pc_q    <= inst_pc_d;
            mem_if_en_q  <= mem_if_en_d;
            mem_if_pc_q  <= mem_if_pc_d;
            if (fill_we) begin
                valid_q[fill_idx] <= 1'b1;
            end
        end
    end

    // Tag and data arrays carry no reset; valid alone qualifies them.
    always_ff @(posedge clk) begin
        if (fill_we) begin
            tag_q[fill_idx]  <= fill_tag;
            data_q[fill_idx] <= mem_if_data;
        end
    end

    assign inst_valid = inst_valid_q;
    assign inst       = inst_q;
    assign inst_pc    = inst_pc_q;
    assign mem_if_en  = mem_if_en_q;
    assign mem_if_pc  = mem_if_pc_q;

endmodule

// File: tb/tb_icache_fetch.sv
// Self-checking bench for icache_fetch: directed scenarios plus randomized traffic,
// checked every cycle against a line-address level model of the cache and MemCtrl.
module tb_icache_fetch;

    localparam int unsigned LB  = 64;
    localparam int unsigned NL  = 16;
    localparam int unsigned WPL = LB / 4;

    logic             clk = 1'b0;
    logic             rst;
    logic             rdy;
    logic             rollback;
    logic             fetch_en;
    logic [31:0]      fetch_pc;
    logic             inst_valid;
    logic [31:0]      inst;
    logic [31:0]      inst_pc;
    logic             mem_if_en;
    logic [31:0]      mem_if_pc;
    logic             mem_if_done;
    logic [LB*8-1:0]  mem_if_data;

    always #5 clk = ~clk;

    icache_fetch #(
        .LINE_BYTES (LB),
        .NUM_LINES  (NL)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .rdy         (rdy),
        .rollback    (rollback),
        .fetch_en    (fetch_en),
        .fetch_pc    (fetch_pc),
        .inst_valid  (inst_valid),
        .inst        (inst),
        .inst_pc     (inst_pc),
        .mem_if_en   (mem_if_en),
        .mem_if_pc   (mem_if_pc),
        .mem_if_done (mem_if_done),
        .mem_if_data (mem_if_data)
    );

    int total = 0;
    int bad   = 0;

    // Model: which line address each set holds, plus the outstanding request.
    logic [31:0] m_line [NL];
    bit          m_has  [NL];
    bit          busy;
    logic [31:0] req;
    int          lat;
    bit          hold_done;
    bit          chk_on;

    logic        e_valid;
    logic [31:0] e_inst;
    logic [31:0] e_pc;
    logic        e_en;
    logic [31:0] e_mpc;

    // Backing memory contents: an address hash, so word 0 of line 0 is 0x00000013.
    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return 32'h0000_0013 ^ ((a & 32'hFFFF_FFFC) * 32'h9E37_79B1);
    endfunction

    function automatic logic [31:0] base_of(input logic [31:0] a);
        return a & ~32'(LB - 1);
    endfunction

    function automatic int idx_of(input logic [31:0] a);
        return int'((a / LB) % NL);
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < int'(NL); i++) begin
            m_has[i]  = 1'b0;
            m_line[i] = '0;
        end
        busy    = 1'b0;
        req     = '0;
        lat     = 0;
        e_valid = 1'b0;
        e_inst  = '0;
        e_pc    = '0;
        e_en    = 1'b0;
        e_mpc   = '0;
    endtask

    always @(negedge clk) begin
        if (chk_on) begin
            check("inst_valid", {31'b0, inst_valid}, {31'b0, e_valid});
            check("mem_if_en", {31'b0, mem_if_en}, {31'b0, e_en});
            check("mem_if_pc", mem_if_pc, e_mpc);
            if (e_valid) begin
                check("inst", inst, e_inst);
                check("inst_pc", inst_pc, e_pc);
            end
        end
    end

    // One clock: drive inputs, answer as MemCtrl, then advance the model across the edge.
    task automatic step(input bit en, input logic [31:0] pc, input bit rb, input bit r);
        int k;
        fetch_en    = en;
        fetch_pc    = pc;
        rollback    = rb;
        rdy         = r;
        mem_if_done = 1'b0;
        for (int i = 0; i < int'(WPL); i++) mem_if_data[32*i +: 32] = $urandom;
        if (busy) begin
            if (lat == 0 && !hold_done) begin
                mem_if_done = 1'b1;
                for (int i = 0; i < int'(WPL); i++)
                    mem_if_data[32*i +: 32] = mem_word(req + 32'(4 * i));
                lat = $urandom_range(0, 3);
            end else if (lat > 0) begin
                lat--;
            end
        end else if ($urandom_range(0, 19) == 0) begin
            mem_if_done = 1'b1;
        end
        @(posedge clk);
        if (rst) begin
            e_valid = 1'b0;
            if (rdy) begin
                if (busy) begin
                    if (mem_if_done) begin
                        k         = idx_of(req);
                        m_line[k] = req;
                        m_has[k]  = 1'b1;
                        busy      = 1'b0;
                        e_en      = 1'b0;
                    end
                end else if (fetch_en && !rollback) begin
                    k = idx_of(fetch_pc);
                    if (m_has[k] && m_line[k] == base_of(fetch_pc)) begin
                        e_valid = 1'b1;
                        e_inst  = mem_word(fetch_pc);
                        e_pc    = fetch_pc;
                    end else begin
                        busy  = 1'b1;
                        req   = base_of(fetch_pc);
                        e_en  = 1'b1;
                        e_mpc = req;
                        lat   = $urandom_range(0, 3);
                    end
                end
            end
        end
        @(negedge clk);
    endtask

    task automatic wait_idle(input bit rb);
        int n = 0;
        while (mem_if_en && n < 40) begin
            step(1'b0, 32'h0, rb, 1'b1);
            n++;
        end
        check("fill_timeout", {31'b0, mem_if_en}, 32'd0);
    endtask

    initial begin
        int n;
        chk_on      = 1'b0;
        hold_done   = 1'b0;
        rst         = 1'b0;
        rdy         = 1'b1;
        rollback    = 1'b0;
        fetch_en    = 1'b0;
        fetch_pc    = '0;
        mem_if_done = 1'b0;
        mem_if_data = '0;
        model_reset();
        @(negedge clk);
        @(negedge clk);
        check("rst_inst_valid", {31'b0, inst_valid}, 32'd0);
        check("rst_mem_if_en", {31'b0, mem_if_en}, 32'd0);
        check("rst_mem_if_pc", mem_if_pc, 32'd0);
        check("rst_inst", inst, 32'd0);
        check("rst_inst_pc", inst_pc, 32'd0);
        rst    = 1'b1;
        chk_on = 1'b1;

        // Cold miss on 0x0.
        step(1'b1, 32'h0, 1'b0, 1'b1);
        check("t1_req_en", {31'b0, mem_if_en}, 32'd1);
        check("t1_req_pc", mem_if_pc, 32'h0);
        n = 0;
        while (!inst_valid && n < 20) begin
            step(1'b1, 32'h0, 1'b0, 1'b1);
            n++;
        end
        check("t1_valid", {31'b0, inst_valid}, 32'd1);
        check("t1_inst", inst, 32'h0000_0013);
        check("t1_inst_pc", inst_pc, 32'h0);

        // Hit stream through words 1..3.
        for (int w = 1; w <= 3; w++) begin
            step(1'b1, 32'(4 * w), 1'b0, 1'b1);
            check("t2_valid", {31'b0, inst_valid}, 32'd1);
            check("t2_no_req", {31'b0, mem_if_en}, 32'd0);
            if (w == 1) check("t2_word1", inst, 32'h78DD_E6D7);
        end

        // Conflict in set 0: 0x400 evicts 0x0, then 0x0 misses again.
        step(1'b1, 32'h400, 1'b0, 1'b1);
        check("t3_req_en", {31'b0, mem_if_en}, 32'd1);
        check("t3_req_pc", mem_if_pc, 32'h400);
        wait_idle(1'b0);
        step(1'b1, 32'h0, 1'b0, 1'b1);
        check("t3_remiss_en", {31'b0, mem_if_en}, 32'd1);
        check("t3_remiss_pc", mem_if_pc, 32'h0);
        wait_idle(1'b0);

        // Rollback while waiting: the fill still lands, no instruction for it.
        step(1'b1, 32'h40, 1'b0, 1'b1);
        hold_done = 1'b1;
        step(1'b1, 32'h40, 1'b1, 1'b1);
        step(1'b1, 32'h44, 1'b1, 1'b1);
        check("t4_held_en", {31'b0, mem_if_en}, 32'd1);
        check("t4_held_pc", mem_if_pc, 32'h40);
        hold_done = 1'b0;
        wait_idle(1'b1);
        step(1'b1, 32'h40, 1'b0, 1'b1);
        check("t4_hit", {31'b0, inst_valid}, 32'd1);
        check("t4_hit_pc", inst_pc, 32'h40);

        // Freeze for 3 cycles mid-miss.
        step(1'b1, 32'h800, 1'b0, 1'b1);
        hold_done = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step(1'b1, $urandom, 1'b0, 1'b0);
            check("t5_frz_en", {31'b0, mem_if_en}, 32'd1);
            check("t5_frz_pc", mem_if_pc, 32'h800);
            check("t5_frz_valid", {31'b0, inst_valid}, 32'd0);
        end
        hold_done = 1'b0;
        wait_idle(1'b0);
        step(1'b1, 32'h800, 1'b0, 1'b1);
        check("t5_resume", {31'b0, inst_valid}, 32'd1);
        check("t5_resume_pc", inst_pc, 32'h800);

        // Asynchronous reset in the middle of a miss.
        step(1'b1, 32'h80, 1'b0, 1'b1);
        hold_done = 1'b1;
        step(1'b0, 32'h0, 1'b0, 1'b1);
        mem_if_done = 1'b0;
        #2;
        rst = 1'b0;
        #1;
        check("t6_async_en", {31'b0, mem_if_en}, 32'd0);
        check("t6_async_pc", mem_if_pc, 32'd0);
        model_reset();
        hold_done = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        step(1'b1, 32'h0, 1'b0, 1'b1);
        check("t6_cold_again", {31'b0, mem_if_en}, 32'd1);
        wait_idle(1'b0);

        // Randomized traffic; most PCs fall in 2 KiB so sets conflict and hits are common.
        repeat (3000) begin
            logic [31:0] pc;
            if ($urandom_range(0, 9) < 7) pc = 32'($urandom_range(0, 32'h7FF));
            else                          pc = $urandom;
            step($urandom_range(0, 9) < 8, pc, $urandom_range(0, 9) == 0,
                 $urandom_range(0, 9) != 0);
        end

        chk_on = 1'b0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
